// File: rtl/vga_pkg.sv
// Shared constants and types for the 640x480@60 scanout and the 160x120x3 framebuffer.
// Screen timing is held as 10-bit coordinates so counter comparisons stay width-matched.
package vga_pkg;

  typedef logic [9:0]  coord_t;
  typedef logic [14:0] fb_addr_t;
  typedef logic [2:0]  colour_t;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  localparam coord_t H_VISIBLE    = 10'd640;
  localparam coord_t H_FRONT      = 10'd16;
  localparam coord_t H_SYNC       = 10'd96;
  localparam coord_t H_BACK       = 10'd48;
  localparam coord_t H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam coord_t H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam coord_t H_LAST       = H_SYNC_END + H_BACK - 10'd1;

  localparam coord_t V_VISIBLE    = 10'd480;
  localparam coord_t V_FRONT      = 10'd10;
  localparam coord_t V_SYNC       = 10'd2;
  localparam coord_t V_BACK       = 10'd33;
  localparam coord_t V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam coord_t V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam coord_t V_LAST       = V_SYNC_END + V_BACK - 10'd1;

  localparam int       FB_W      = 160;
  localparam int       FB_H      = 120;
  localparam int       FB_DEPTH  = FB_W * FB_H;
  localparam int       SCALE_SH  = 2;
  localparam fb_addr_t FB_LAST   = fb_addr_t'(FB_DEPTH - 1);
  localparam colour_t  BG_COLOUR = 3'b000;

  // Row-major framebuffer address of an in-range (col, row).
  function automatic fb_addr_t fb_index(input logic [7:0] col, input logic [6:0] row);
    return fb_addr_t'(row) * fb_addr_t'(FB_W) + fb_addr_t'(col);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-enable divider and 800x525 scan counters; raw (undelayed) sync and visible flags.
module vga_timing
  import vga_pkg::*;
(
  input  logic   clk,
  input  logic   resetn,
  output logic   pe,
  output coord_t h,
  output coord_t v,
  output logic   hs_raw,
  output logic   vs_raw,
  output logic   visible,
  output logic   frame_start
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pe          <= 1'b0;
      h           <= '0;
      v           <= '0;
      frame_start <= 1'b0;
    end else begin
      pe          <= ~pe;
      frame_start <= pe && (h == H_LAST) && (v == V_LAST);
      if (pe) begin
        if (h == H_LAST) begin
          h <= '0;
          v <= (v == V_LAST) ? '0 : v + 10'd1;
        end else begin
          h <= h + 10'd1;
        end
      end
    end
  end

  assign hs_raw  = !((h >= H_SYNC_START) && (h < H_SYNC_END));
  assign vs_raw  = !((v >= V_SYNC_START) && (v < V_SYNC_END));
  assign visible = (h < H_VISIBLE) && (v < V_VISIBLE);

endmodule

// File: rtl/pixel_framebuffer_scanout.sv
// Plot-port sink, 160x120x3 framebuffer with clear sweeper, and 4x-scaled VGA scanout.
// Sync, blank and colour all pass through the same two pixel-enable stages to stay aligned.
module pixel_framebuffer_scanout
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  colour_t    colour,
  input  logic       plot,
  input  logic       clear,
  output logic       plot_ready,
  output logic       frame_start,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [9:0] VGA_R,
  output logic [9:0] VGA_G,
  output logic [9:0] VGA_B
);

  logic   pe, hs_raw, vs_raw, visible;
  coord_t h, v;

  vga_timing u_timing (
    .clk        (clk),
    .resetn     (resetn),
    .pe         (pe),
    .h          (h),
    .v          (v),
    .hs_raw     (hs_raw),
    .vs_raw     (vs_raw),
    .visible    (visible),
    .frame_start(frame_start)
  );

  state_t   state, state_nx;
  fb_addr_t clr_addr, clr_addr_nx;
  logic     we;
  fb_addr_t wr_addr;
  colour_t  wr_data;
  logic     plot_ok;

  // Out-of-range coordinates are rejected outright rather than wrapping into the next row.
  assign plot_ok    = plot && (x < 8'(FB_W)) && (y < 7'(FB_H));
  assign plot_ready = (state == S_RUN);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nx;
      clr_addr <= clr_addr_nx;
    end
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_nx    = state;
    clr_addr_nx = clr_addr;
    we          = 1'b0;
    wr_addr     = clr_addr;
    wr_data     = BG_COLOUR;
    case (state)
      S_CLEAR: begin
        we = 1'b1;
        if (clear) begin
          clr_addr_nx = '0;
        end else if (clr_addr == FB_LAST) begin
          state_nx    = S_RUN;
          clr_addr_nx = '0;
        end else begin
          clr_addr_nx = clr_addr + 1'b1;
        end
      end
      S_RUN: begin
        if (clear) begin
          state_nx    = S_CLEAR;
          clr_addr_nx = '0;
        end else if (plot_ok) begin
          we      = 1'b1;
          wr_addr = fb_index(x, y);
          wr_data = colour;
        end
      end
      default: state_nx = S_CLEAR;
    endcase
  end

  // Address is forced to 0 in blanking so the scaled counters never index past the array.
  fb_addr_t rd_addr;
  assign rd_addr = visible ? fb_index(8'(h >> SCALE_SH), 7'(v >> SCALE_SH)) : '0;

  colour_t fb_mem [FB_DEPTH];
  colour_t rd_data;

  // NOTE: the framebuffer array has no reset; the clear sweep after reset initialises it.
  always_ff @(posedge clk) begin
    if (we) fb_mem[wr_addr] <= wr_data;
    if (pe) rd_data <= fb_mem[rd_addr];
  end

  logic    s1_hs, s1_vs, s1_vis;
  colour_t rgb_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_hs       <= 1'b1;
      s1_vs       <= 1'b1;
      s1_vis      <= 1'b0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      rgb_q       <= '0;
    end else if (pe) begin
      s1_hs       <= hs_raw;
      s1_vs       <= vs_raw;
      s1_vis      <= visible;
      VGA_HS      <= s1_hs;
      VGA_VS      <= s1_vs;
      VGA_BLANK_N <= s1_vis;
      rgb_q       <= s1_vis ? rd_data : '0;
    end
  end

  assign VGA_CLK    = pe;
  assign VGA_SYNC_N = 1'b1;
  assign VGA_R      = {10{rgb_q[2]}};
  assign VGA_G      = {10{rgb_q[1]}};
  assign VGA_B      = {10{rgb_q[0]}};

endmodule

// File: tb/tb_pixel_framebuffer_scanout.sv
// Bench: a screen/framebuffer model derived from edge counts checks every pin on every negedge,
// while directed vectors pin sweep timing, plot placement, sync widths and async reset.
`timescale 1ns/1ps
module tb_pixel_framebuffer_scanout;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic [7:0] x = '0;
  logic [6:0] y = '0;
  logic [2:0] colour = '0;
  logic       plot = 1'b0;
  logic       clear = 1'b0;
  logic       plot_ready, frame_start, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
  logic [9:0] VGA_R, VGA_G, VGA_B;

  always #10 clk = ~clk;

  pixel_framebuffer_scanout dut (
    .clk(clk), .resetn(resetn), .x(x), .y(y), .colour(colour), .plot(plot), .clear(clear),
    .plot_ready(plot_ready), .frame_start(frame_start), .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS),
    .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: k = clk edges since reset release; sweep_start = edge at which the latest sweep began.
  int       k = 0;
  int       sweep_start = 0;
  bit [2:0] fb_old [19200];
  bit [2:0] fb_new [19200];
  int       fb_wt  [19200];

  task automatic model_clear();
    for (int i = 0; i < 19200; i++) begin
      fb_old[i] = 3'b000;
      fb_new[i] = 3'b000;
      fb_wt[i]  = 0;
    end
  endtask

  task automatic model_plot(input int xx, input int yy, input int c, input int w);
    int a;
    if (xx < 160 && yy < 120) begin
      a         = yy * 160 + xx;
      fb_old[a] = fb_new[a];
      fb_new[a] = 3'(c);
      fb_wt[a]  = w;
    end
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) k = 0;
    else         k = k + 1;
  end

  function automatic logic [9:0] chan(input bit b);
    return b ? 10'h3FF : 10'h000;
  endfunction

  always @(negedge clk) begin
    int idx, hh, vv, a, r;
    bit vis;
    bit [2:0] c;
    check("sync_n", VGA_SYNC_N, 1);
    if (!resetn) begin
      check("rst_ready", plot_ready, 0);
      check("rst_hs", VGA_HS, 1);
      check("rst_vs", VGA_VS, 1);
      check("rst_blank_n", VGA_BLANK_N, 0);
      check("rst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
    end else begin
      idx = k / 2 - 2;
      check("vga_clk", VGA_CLK, 32'(k % 2));
      check("plot_ready", plot_ready, 32'(k - sweep_start >= 19200));
      check("frame_start", frame_start, 32'(k > 0 && k % 840000 == 0));
      if (idx < 0) begin
        check("early_hs", VGA_HS, 1);
        check("early_vs", VGA_VS, 1);
        check("early_blank_n", VGA_BLANK_N, 0);
        check("early_rgb", {VGA_R, VGA_G, VGA_B}, 0);
      end else begin
        hh  = idx % 800;
        vv  = (idx / 800) % 525;
        vis = (hh < 640) && (vv < 480);
        check("hs", VGA_HS, 32'(!(hh >= 656 && hh < 752)));
        check("vs", VGA_VS, 32'(!(vv >= 490 && vv < 492)));
        check("blank_n", VGA_BLANK_N, 32'(vis));
        if (!vis) begin
          check("blank_rgb", {VGA_R, VGA_G, VGA_B}, 0);
        end else if (k - sweep_start >= 19208) begin
          a = (vv / 4) * 160 + hh / 4;
          r = 2 * idx + 2;
          c = (fb_wt[a] < r) ? fb_new[a] : fb_old[a];
          check("r", VGA_R, chan(c[2]));
          check("g", VGA_G, chan(c[1]));
          check("b", VGA_B, chan(c[0]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_k(input int target);
    while (k < target) tick();
  endtask

  task automatic do_plot(input int xx, input int yy, input int c);
    x      = 8'(xx);
    y      = 7'(yy);
    colour = 3'(c);
    plot   = 1'b1;
    model_plot(xx, yy, c, k + 1);
    tick();
    plot = 1'b0;
  endtask

  initial begin
    int n;
    model_clear();
    #1 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;

    n = 0;
    for (int i = 0; i < 20000; i++) begin
      tick();
      n++;
      if (plot_ready) break;
    end
    check("ready_after_reset", n, 19200);
    repeat (20) tick();

    // Clear and plot together in run state: the clear wins and starts a sweep.
    x = 8'd1; y = 7'd12; colour = 3'b110; plot = 1'b1; clear = 1'b1;
    tick();
    plot = 1'b0; clear = 1'b0;
    sweep_start = k;
    model_clear();
    check("ready_after_clear", plot_ready, 0);

    // Second clear lands while the sweep is at address 5000.
    repeat (5000) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    sweep_start = k;

    n = 0;
    for (int i = 0; i < 20000; i++) begin
      if (i == 8000) begin
        check("ready_mid_sweep", plot_ready, 0);
        x = 8'd0; y = 7'd12; colour = 3'b111; plot = 1'b1;
      end
      tick();
      plot = 1'b0;
      n++;
      if (plot_ready) break;
    end
    check("ready_after_restart", n, 19200);

    do_plot(10, 12, 3'b100);
    do_plot(159, 11, 3'b111);
    do_plot(0, 13, 3'b011);
    do_plot(160, 9, 3'b111);
    do_plot(0, 120, 3'b101);

    wait_k(64004);
    check("no_wrap_r", VGA_R, 10'h000);
    wait_k(76804);
    check("dropped_plot_g", VGA_G, 10'h000);
    wait_k(76882);
    check("left_of_block_r", VGA_R, 10'h000);
    wait_k(76884);
    check("block_first_r", VGA_R, 10'h3FF);
    check("block_first_gb", {VGA_G, VGA_B}, 20'h0);
    wait_k(76892);
    check("right_of_block_r", VGA_R, 10'h000);
    wait_k(81690);
    check("block_last_r", VGA_R, 10'h3FF);
    wait_k(83204);
    check("cyan_rgb", {VGA_R, VGA_G, VGA_B}, {10'h000, 10'h3FF, 10'h3FF});
    wait_k(83210);
    check("cyan_before_reset", VGA_G, 10'h3FF);

    // Asynchronous reset mid-line, between clock edges.
    #3 resetn = 1'b0;
    #1;
    check("async_hs", VGA_HS, 1);
    check("async_blank_n", VGA_BLANK_N, 0);
    check("async_rgb", {VGA_R, VGA_G, VGA_B}, 0);
    check("async_ready", plot_ready, 0);
    model_clear();
    sweep_start = 0;
    @(posedge clk);
    #2 resetn = 1'b1;

    n = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      n++;
      if (VGA_HS == 1'b0) break;
    end
    check("hs_first_fall", n, 1316);
    check("hs_fall_blank_n", VGA_BLANK_N, 0);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      n++;
      if (VGA_HS == 1'b1) break;
    end
    check("hs_low_width", n, 192);
    for (int i = 0; i < 2000; i++) begin
      tick();
      n++;
      if (VGA_HS == 1'b0) break;
    end
    check("hs_period", n, 1600);

    tick();
    #3 resetn = 1'b0;
    #1;
    check("async_hs_from_low", VGA_HS, 1);
    @(posedge clk);
    #2 resetn = 1'b1;
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
